// File: rtl/sat_dec_timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sat_dec_timer_bank_pkg
// Brief    : Shared constants and types for the saturating down-counter bank.
//            Optional feature macro used by the bank: SAT_DEC_TIMER_RELOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
package sat_dec_timer_bank_pkg;

    // Default geometry: 4-bit counts, 4 channels
    localparam int N_DEFAULT = 4;
    localparam int C_DEFAULT = 4;

    // Per-channel control bits sliced out of the packed strobe buses
    typedef struct packed {
        logic load;
        logic enable;
    } chan_ctrl_t;

    // Channel state at the default width (count register plus reload register)
    typedef struct packed {
        logic [N_DEFAULT-1:0] count;
        logic [N_DEFAULT-1:0] reload;
    } chan_state_t;

endpackage : sat_dec_timer_bank_pkg
`default_nettype wire

// File: rtl/sat_dec_channel.sv
`default_nettype none
// ============================================================================
// Module   : sat_dec_channel
// Brief    : One saturating down-counter: load, tick-gated decrement floored
//            at zero, zero flag and single-cycle expiry pulse. With
//            SAT_DEC_TIMER_RELOAD_EN defined, a reload register makes the
//            channel periodic.
// Revision : 1.0 - initial release
// ============================================================================
module sat_dec_channel
    import sat_dec_timer_bank_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  chan_ctrl_t   i_ctrl,
    input  logic [N-1:0] i_load_val,
    output logic [N-1:0] o_count,
    output logic         o_zero,
    output logic         o_expire
);

    localparam logic [N-1:0] C_ZERO = '0;
    localparam logic [N-1:0] C_ONE  = N'(1);

    logic [N-1:0] count_d, count_q;
    logic         expire_d, expire_q;
`ifdef SAT_DEC_TIMER_RELOAD_EN
    logic [N-1:0] reload_d, reload_q;
`endif

    // Next-state: load beats tick; decrement stops at zero; expiry only on 1->0
    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
`ifdef SAT_DEC_TIMER_RELOAD_EN
        reload_d = reload_q;
`endif
        if (i_ctrl.load) begin
            count_d  = i_load_val;
`ifdef SAT_DEC_TIMER_RELOAD_EN
            reload_d = i_load_val;
`endif
        end else if (i_tick && i_ctrl.enable) begin
            if (count_q == C_ONE) begin
`ifdef SAT_DEC_TIMER_RELOAD_EN
                count_d = reload_q;
`else
                count_d = C_ZERO;
`endif
                expire_d = 1'b1;
            end else if (count_q != C_ZERO) begin
                count_d = count_q - C_ONE;
            end
        end
    end

    // State registers; reset aborts counting and drops any pending expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= C_ZERO;
            expire_q <= 1'b0;
`ifdef SAT_DEC_TIMER_RELOAD_EN
            reload_q <= C_ZERO;
`endif
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
`ifdef SAT_DEC_TIMER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign o_count  = count_q;
    assign o_zero   = (count_q == C_ZERO);
    assign o_expire = expire_q;

endmodule : sat_dec_channel
`default_nettype wire

// File: rtl/sat_dec_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : sat_dec_timer_bank
// Brief    : Bank of C independent N-bit saturating down-counters sharing one
//            tick strobe. Optional periodic reload under the macro
//            SAT_DEC_TIMER_RELOAD_EN (port list identical in both builds).
// Revision : 1.0 - initial release
// ============================================================================
module sat_dec_timer_bank
    import sat_dec_timer_bank_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int C = C_DEFAULT
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Tick,
    input  logic [C-1:0]   Enable,
    input  logic [C-1:0]   LoadEn,
    input  logic [C*N-1:0] LoadVal,
    output logic [C*N-1:0] Count,
    output logic [C-1:0]   Zero,
    output logic [C-1:0]   Expire
);

    // One channel per slice of the packed buses
    for (genvar gi = 0; gi < C; gi++) begin : g_chan
        chan_ctrl_t w_ctrl;

        assign w_ctrl.load   = LoadEn[gi];
        assign w_ctrl.enable = Enable[gi];

        sat_dec_channel #(
            .N (N)
        ) u_chan (
            .clk        (Clk),
            .rst        (Rst),
            .i_tick     (Tick),
            .i_ctrl     (w_ctrl),
            .i_load_val (LoadVal[gi*N +: N]),
            .o_count    (Count[gi*N +: N]),
            .o_zero     (Zero[gi]),
            .o_expire   (Expire[gi])
        );
    end : g_chan

endmodule : sat_dec_timer_bank
`default_nettype wire
